// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared scalar typedefs, ALU op codes and forwarding-select enum.
//   Imported by id_ex_stage_if, id_ex_stage_forward_unit and id_ex_stage.
package id_ex_stage_pkg;
   typedef logic [31:0] u32;
   typedef logic [4:0]  u5;
   typedef logic [2:0]  u3;
   typedef logic        u1;
   localparam u3 ALU_AND  = 3'd0;
   localparam u3 ALU_OR   = 3'd1;
   localparam u3 ALU_ADD  = 3'd2;
   localparam u3 ALU_ROR  = 3'd3;
   localparam u3 ALU_RAND = 3'd4;
   localparam u3 ALU_SUB  = 3'd6;
   localparam u3 ALU_SLT  = 3'd7;
   typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundle between decode, the ID/EX stage, later pipeline stages and the ALU.
//   master : decode/pipeline side -- drives decode fields, flush/ex_stall, MEM/WB writeback info
//   slave  : the ID/EX stage -- drives d_ready, ALU operands and EX control
interface id_ex_stage_if #(
   parameter int XLEN = 32,
   parameter int REGW = 5
);
   import id_ex_stage_pkg::*;
   logic            d_valid, d_ready;
   logic [REGW-1:0] d_rs, d_rt, d_wreg;
   logic [XLEN-1:0] d_rd1, d_rd2, d_imm;
   logic            d_alusrc, d_regwrite, d_memtoreg;
   u3               d_alucont;
   logic            flush, ex_stall;
   logic            m_regwrite, w_regwrite;
   logic [REGW-1:0] m_wreg, w_wreg;
   logic [XLEN-1:0] m_result, w_result;
   logic [XLEN-1:0] A, B, e_storedata;
   u3               ALUcont;
   logic            e_valid, e_regwrite, e_memtoreg;
   logic [REGW-1:0] e_wreg;
   modport master (
      output d_valid, d_rs, d_rt, d_wreg, d_rd1, d_rd2, d_imm, d_alusrc, d_regwrite, d_memtoreg, d_alucont,
      output flush, ex_stall, m_regwrite, m_wreg, m_result, w_regwrite, w_wreg, w_result,
      input  d_ready, A, B, ALUcont, e_valid, e_regwrite, e_memtoreg, e_wreg, e_storedata
   );
   modport slave (
      input  d_valid, d_rs, d_rt, d_wreg, d_rd1, d_rd2, d_imm, d_alusrc, d_regwrite, d_memtoreg, d_alucont,
      input  flush, ex_stall, m_regwrite, m_wreg, m_result, w_regwrite, w_wreg, w_result,
      output d_ready, A, B, ALUcont, e_valid, e_regwrite, e_memtoreg, e_wreg, e_storedata
   );
endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// id_ex_stage_forward_unit: picks the operand source for one source register.
//   idx                  : source register index held in EX
//   m_regwrite, m_wreg   : EX/MEM writeback info
//   w_regwrite, w_wreg   : MEM/WB writeback info
//   sel                  : FWD_REG / FWD_MEM / FWD_WB (MEM wins over WB, register 0 never forwarded)
module id_ex_stage_forward_unit
   import id_ex_stage_pkg::*;
#(
   parameter int REGW = 5
) (
   input  logic [REGW-1:0] idx,
   input  logic            m_regwrite,
   input  logic [REGW-1:0] m_wreg,
   input  logic            w_regwrite,
   input  logic [REGW-1:0] w_wreg,
   output fwd_sel_t        sel
);
   always_comb
      sel = (idx == '0)                       ? FWD_REG :
            (m_regwrite && m_wreg == idx)     ? FWD_MEM :
            (w_regwrite && w_wreg == idx)     ? FWD_WB  : FWD_REG;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU, with load-use bubbles and decode handshake.
//   clk    : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : id_ex_stage_if.slave -- decode fields/d_ready, flush, ex_stall, MEM/WB writeback info,
//            ALU operands A/B/ALUcont and EX control e_valid/e_regwrite/e_memtoreg/e_wreg/e_storedata
//   Macro ALU_FWD_EN: defined -> operands forwarded from MEM/WB; undefined -> no operand muxing and
//            dependents wait in decode until the producer reaches WB (write-through regfile).
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic         clk,
   input  logic         resetn,
   id_ex_stage_if.slave bus
);
   logic [XLEN-1:0] rd1_q, rd2_q, imm_q, fwd_a, fwd_b;
   logic [REGW-1:0] wreg_q;
   logic            valid_q, regwrite_q, memtoreg_q, alusrc_q;
   u3               alucont_q;
   logic            load_use, hazard, load;
   // Rule is conservative: rt is compared even when it is not consumed.
   assign load_use = valid_q && memtoreg_q && wreg_q != '0 && bus.d_valid &&
                     (wreg_q == bus.d_rs || wreg_q == bus.d_rt);
`ifdef ALU_FWD_EN
   logic [REGW-1:0] rs_q, rt_q;
   fwd_sel_t        sel_a, sel_b;
   always_ff @(posedge clk)
      if (!resetn) begin
         rs_q <= '0;
         rt_q <= '0;
      end else if (load) begin
         rs_q <= bus.d_rs;
         rt_q <= bus.d_rt;
      end
   id_ex_stage_forward_unit #(.REGW(REGW)) u_fwd_a (
      .idx(rs_q), .m_regwrite(bus.m_regwrite), .m_wreg(bus.m_wreg),
      .w_regwrite(bus.w_regwrite), .w_wreg(bus.w_wreg), .sel(sel_a)
   );
   id_ex_stage_forward_unit #(.REGW(REGW)) u_fwd_b (
      .idx(rt_q), .m_regwrite(bus.m_regwrite), .m_wreg(bus.m_wreg),
      .w_regwrite(bus.w_regwrite), .w_wreg(bus.w_wreg), .sel(sel_b)
   );
   assign hazard = load_use;
   assign fwd_a  = sel_a == FWD_MEM ? bus.m_result : sel_a == FWD_WB ? bus.w_result : rd1_q;
   assign fwd_b  = sel_b == FWD_MEM ? bus.m_result : sel_b == FWD_WB ? bus.w_result : rd2_q;
`else
   // Without forwarding any in-flight writer of a source in EX or MEM blocks decode; once it is in
   // WB the write-through register file already returns the new value.
   assign hazard = load_use || (bus.d_valid && (
                      (valid_q && regwrite_q && wreg_q != '0 && (wreg_q == bus.d_rs || wreg_q == bus.d_rt)) ||
                      (bus.m_regwrite && bus.m_wreg != '0 && (bus.m_wreg == bus.d_rs || bus.m_wreg == bus.d_rt))));
   assign fwd_a  = rd1_q;
   assign fwd_b  = rd2_q;
`endif
   assign load = bus.d_valid && !hazard && !bus.flush && !bus.ex_stall;
   // Flush clears only valid; a bubble also clears the writeback controls.
   always_ff @(posedge clk)
      if (!resetn) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         alusrc_q   <= 1'b0;
         alucont_q  <= '0;
         wreg_q     <= '0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         imm_q      <= '0;
      end else if (!bus.ex_stall) begin
         valid_q    <= load;
         regwrite_q <= load ? bus.d_regwrite : bus.flush ? regwrite_q : 1'b0;
         memtoreg_q <= load ? bus.d_memtoreg : bus.flush ? memtoreg_q : 1'b0;
         if (load) begin
            alusrc_q  <= bus.d_alusrc;
            alucont_q <= bus.d_alucont;
            wreg_q    <= bus.d_wreg;
            rd1_q     <= bus.d_rd1;
            rd2_q     <= bus.d_rd2;
            imm_q     <= bus.d_imm;
         end
      end
   assign bus.d_ready     = !bus.ex_stall && !hazard;
   assign bus.A           = fwd_a;
   assign bus.B           = alusrc_q ? imm_q : fwd_b;
   assign bus.e_storedata = fwd_b;
   assign bus.ALUcont     = alucont_q;
   assign bus.e_valid     = valid_q;
   assign bus.e_regwrite  = valid_q && regwrite_q;
   assign bus.e_memtoreg  = valid_q && memtoreg_q;
   assign bus.e_wreg      = wreg_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage against an in-order architectural register model.
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;
`ifdef ALU_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   typedef struct {
      logic [4:0]  rs, rt, wreg;
      logic [31:0] imm;
      logic        alusrc;
      logic [2:0]  op;
      logic        rw, mtr;
   } instr_t;
   typedef struct packed {
      logic [31:0] a, b, sd;
      logic [2:0]  op;
      logic [4:0]  wreg;
      logic        rw, mtr;
   } exp_t;

   logic clk = 1'b0, resetn = 1'b0;
   always #5 clk = ~clk;

   id_ex_stage_if bus ();
   id_ex_stage dut (.clk(clk), .resetn(resetn), .bus(bus));

   int checks = 0, passes = 0;
   exp_t q[$];
   logic [31:0] init_regs[32], regs[32], arch[32];

   function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      case (op)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
         ALU_ROR: return (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}));
         default: return a ^ b;
      endcase
   endfunction

   function automatic logic [31:0] mem_fn(input logic [31:0] addr);
      return {addr[15:0], ~addr[15:0]} ^ 32'h1234_0000;
   endfunction

   // Downstream MEM/WB stages and register file driven by the stage's own outputs.
   logic        m_v, m_rw, m_mtr, w_v, w_rw, w_mtr;
   logic [4:0]  m_wreg, w_wreg;
   logic [31:0] m_alu, w_alu;
   always @(posedge clk)
      if (!resetn) begin
         {m_v, m_rw, m_mtr, w_v, w_rw, w_mtr} <= '0;
         m_wreg <= '0; w_wreg <= '0; m_alu <= '0; w_alu <= '0;
         regs <= init_regs;
      end else begin
         if (bus.w_regwrite && w_wreg != 5'd0) regs[w_wreg] <= bus.w_result;
         if (!bus.ex_stall) begin
            m_v <= bus.e_valid; m_rw <= bus.e_regwrite; m_mtr <= bus.e_memtoreg;
            m_wreg <= bus.e_wreg; m_alu <= alu(bus.A, bus.B, bus.ALUcont);
            w_v <= m_v; w_rw <= m_rw; w_mtr <= m_mtr; w_wreg <= m_wreg; w_alu <= m_alu;
         end
      end
   assign bus.m_regwrite = m_v && m_rw;
   assign bus.m_wreg     = m_wreg;
   assign bus.m_result   = m_alu;
   assign bus.w_regwrite = w_v && w_rw;
   assign bus.w_wreg     = w_wreg;
   assign bus.w_result   = w_mtr ? mem_fn(w_alu) : w_alu;
   assign bus.d_rd1 = bus.d_rs == 5'd0 ? 32'd0 : (bus.w_regwrite && bus.w_wreg == bus.d_rs) ? bus.w_result : regs[bus.d_rs];
   assign bus.d_rd2 = bus.d_rt == 5'd0 ? 32'd0 : (bus.w_regwrite && bus.w_wreg == bus.d_rt) ? bus.w_result : regs[bus.d_rt];

   // Monitor: compare each instruction on its last cycle in EX.
   exp_t got, want;
   always @(negedge clk)
      if (resetn && bus.e_valid && !bus.ex_stall) begin
         got = '{a: bus.A, b: bus.B, sd: bus.e_storedata, op: bus.ALUcont, wreg: bus.e_wreg,
                 rw: bus.e_regwrite, mtr: bus.e_memtoreg};
         checks++;
         if (q.size() == 0) $display("FAIL ex_unexpected got=%h (no instruction expected)", got);
         else begin
            want = q.pop_front();
            if (got === want) passes++;
            else $display("FAIL ex_out got=%h exp=%h", got, want);
         end
      end

   task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
      checks++;
      if (g === e) passes++;
      else $display("FAIL %s got=%h exp=%h", name, g, e);
   endtask

   function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wreg,
                                 input logic [31:0] imm, input logic alusrc, input logic [2:0] op,
                                 input logic rw, input logic mtr);
      instr_t i;
      i.rs = rs; i.rt = rt; i.wreg = wreg; i.imm = imm; i.alusrc = alusrc; i.op = op; i.rw = rw; i.mtr = mtr;
      return i;
   endfunction

   function automatic instr_t rnd_instr();
      instr_t i;
      int k = $urandom_range(0, 9);
      i = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1, 1'b0);
      if (k < 2) begin i.mtr = 1'b1; i.alusrc = 1'b1; i.op = ALU_ADD; end
      else if (k < 4) i.rw = 1'b0;
      return i;
   endfunction

   // Architectural model: operands are the in-order register values at issue.
   task automatic model(input instr_t i);
      exp_t e;
      logic [31:0] r;
      e.a = arch[i.rs]; e.sd = arch[i.rt]; e.b = i.alusrc ? i.imm : arch[i.rt];
      e.op = i.op; e.wreg = i.wreg; e.rw = i.rw; e.mtr = i.mtr;
      q.push_back(e);
      r = alu(e.a, e.b, i.op);
      if (i.rw && i.wreg != 5'd0) arch[i.wreg] = i.mtr ? mem_fn(r) : r;
   endtask

   task automatic present(input instr_t i);
      bus.d_valid = 1'b1; bus.d_rs = i.rs; bus.d_rt = i.rt; bus.d_wreg = i.wreg; bus.d_imm = i.imm;
      bus.d_alusrc = i.alusrc; bus.d_alucont = i.op; bus.d_regwrite = i.rw; bus.d_memtoreg = i.mtr;
   endtask

   // Called and returns at posedge+1; waits counts non-stalled cycles with d_ready low.
   task automatic issue(input instr_t i, input int stall_pct, input int flush_pct, output int waits);
      bit done = 0;
      waits = 0;
      present(i);
      for (int k = 0; k < 60 && !done; k++) begin
         bus.ex_stall = $urandom_range(0, 99) < stall_pct;
         bus.flush    = $urandom_range(0, 99) < flush_pct;
         @(negedge clk);
         if (bus.d_ready) begin
            done = 1;
            if (!bus.flush) model(i);
         end else if (!bus.ex_stall) waits++;
         @(posedge clk); #1;
      end
      bus.d_valid = 1'b0; bus.ex_stall = 1'b0; bus.flush = 1'b0;
      checks++;
      if (done) passes++;
      else $display("FAIL accept_timeout got=not_accepted exp=accepted rs=%0d rt=%0d", i.rs, i.rt);
   endtask

   task automatic idle(input int n);
      bus.d_valid = 1'b0; bus.ex_stall = 1'b0; bus.flush = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   int w;
   initial begin
      for (int r = 0; r < 32; r++) init_regs[r] = r == 0 ? 32'd0 : $urandom;
      init_regs[9] = 32'd6; init_regs[10] = 32'd3; init_regs[12] = 32'd4;
      arch = init_regs;
      bus.ex_stall = 1'b0; bus.flush = 1'b0;
      present(mk(5'd9, 5'd10, 5'd8, 32'd1, 1'b0, ALU_ADD, 1'b1, 1'b0));
      repeat (2) @(posedge clk);
      #1;
      check("reset_e_valid", {31'b0, bus.e_valid}, 32'd0);
      resetn = 1'b1; bus.d_valid = 1'b0;
      @(negedge clk);
      check("reset_A", bus.A, 32'd0);
      check("reset_B", bus.B, 32'd0);
      check("reset_d_ready", {31'b0, bus.d_ready}, 32'd1);
      @(posedge clk); #1;
      // MEM forward: ADD $8=$9+$10 then SUB $11=$8-$12
      issue(mk(5'd9, 5'd10, 5'd8, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0), 0, 0, w);
      issue(mk(5'd8, 5'd12, 5'd11, 32'd0, 1'b0, ALU_SUB, 1'b1, 1'b0), 0, 0, w);
      check("memfwd_waits", w, FWD ? 32'd0 : 32'd2);
      @(negedge clk);
      check("memfwd_A", bus.A, 32'd9);
      check("memfwd_B", bus.B, 32'd4);
      check("memfwd_op", {29'b0, bus.ALUcont}, {29'b0, ALU_SUB});
      @(posedge clk); #1;
      // MEM beats WB: two writers of $8 back to back
      issue(mk(5'd0, 5'd0, 5'd8, 32'd22, 1'b1, ALU_ADD, 1'b1, 1'b0), 0, 0, w);
      issue(mk(5'd0, 5'd0, 5'd8, 32'd44, 1'b1, ALU_ADD, 1'b1, 1'b0), 0, 0, w);
      issue(mk(5'd8, 5'd9, 5'd13, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0), 0, 0, w);
      check("mem_over_wb_waits", w, FWD ? 32'd0 : 32'd2);
      @(negedge clk);
      check("mem_over_wb_A", bus.A, 32'd44);
      @(posedge clk); #1;
      // Register 0 is never forwarded
      issue(mk(5'd9, 5'd10, 5'd0, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0), 0, 0, w);
      issue(mk(5'd0, 5'd9, 5'd14, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0), 0, 0, w);
      check("r0_waits", w, 32'd0);
      @(negedge clk);
      check("r0_A", bus.A, 32'd0);
      @(posedge clk); #1;
      // Load-use: LW $8 then consumer of $8
      issue(mk(5'd0, 5'd0, 5'd8, 32'd16, 1'b1, ALU_ADD, 1'b1, 1'b1), 0, 0, w);
      issue(mk(5'd8, 5'd9, 5'd15, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0), 0, 0, w);
      check("loaduse_waits", w, FWD ? 32'd1 : 32'd2);
      @(negedge clk);
      check("loaduse_A", bus.A, mem_fn(32'd16));
      @(posedge clk); #1;
      // Immediate path with forwarded rt
      issue(mk(5'd0, 5'd0, 5'd16, 32'd15, 1'b1, ALU_ADD, 1'b1, 1'b0), 0, 0, w);
      issue(mk(5'd9, 5'd16, 5'd17, 32'hffff_fff8, 1'b1, ALU_ADD, 1'b1, 1'b0), 0, 0, w);
      check("imm_waits", w, FWD ? 32'd0 : 32'd2);
      @(negedge clk);
      check("imm_B", bus.B, 32'hffff_fff8);
      check("imm_storedata", bus.e_storedata, 32'd15);
      @(posedge clk); #1;
      // Stall for 3 cycles with a flush pulse in the middle
      issue(mk(5'd9, 5'd10, 5'd18, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0), 0, 0, w);
      for (int c = 0; c < 3; c++) begin
         bus.ex_stall = 1'b1; bus.flush = c == 1;
         @(negedge clk);
         check("stall_A", bus.A, 32'd6);
         check("stall_B", bus.B, 32'd3);
         check("stall_wreg", {27'b0, bus.e_wreg}, 32'd18);
         check("stall_valid", {31'b0, bus.e_valid}, 32'd1);
         @(posedge clk); #1;
      end
      bus.ex_stall = 1'b0; bus.flush = 1'b0;
      @(negedge clk);
      check("after_stall_valid", {31'b0, bus.e_valid}, 32'd1);
      check("after_stall_storedata", bus.e_storedata, 32'd3);
      @(posedge clk); #1;
      // Randomized traffic with stalls, flushes and gaps
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         issue(rnd_instr(), 15, 10, w);
      end
      idle(1);
      for (int k = 0; k < 20 && q.size() > 0; k++) begin @(posedge clk); #1; end
      check("drain_left", q.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
